// File: rtl/rs_scan_pkg.sv
// Shared types and constants for the IO-ring scan-chain initiator.
package rs_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        FINISH
    } state_t;

    localparam int CAPTURE_CYCLES = 1;

endpackage

// File: rtl/rs_scan_shreg.sv
// TX parallel-in/serial-out and RX serial-in/parallel-out registers for the scan chain.
module rs_scan_shreg
    import rs_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift_tx,
    input  logic                 shift_rx,
    input  logic [CHAIN_LEN-1:0] par_in,
    input  logic                 ser_in,
    output logic                 ser_out,
    output logic [CHAIN_LEN-1:0] rx_next
);

    logic [CHAIN_LEN-1:0] tx;
    logic [CHAIN_LEN-1:0] rx;

    // Zero-fill on shift so the serial output falls to 0 once the pattern is fully sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= '0;
        end else if (load) begin
            tx <= par_in;
        end else if (shift_tx) begin
            tx <= {tx[CHAIN_LEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (shift_rx) begin
            rx <= rx_next;
        end
    end

    assign ser_out = tx[CHAIN_LEN-1];
    assign rx_next = {rx[CHAIN_LEN-2:0], ser_in};

endmodule

// File: rtl/rs_scan_ctrl.sv
// Scan-chain initiator: serial load, one capture cycle, serial unload to a parallel result.
// Optional masked compare of the unloaded result is enabled by RS_SCAN_CTRL_COMPARE_EN.
module rs_scan_ctrl
    import rs_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 CK,
    input  logic                 G_RESET,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PATTERN_IN,
    input  logic [CHAIN_LEN-1:0] EXPECT_IN,
    input  logic [CHAIN_LEN-1:0] MASK_IN,
    input  logic                 SO,
    output logic                 SI,
    output logic                 SCAN_ENABLE,
    output logic                 SCAN_MODE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESULT_OUT,
    output logic                 MISMATCH
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt;
    logic                 load;
    logic                 shift_tx;
    logic                 shift_rx;
    logic                 res_upd;
    logic                 done_n;
    logic [CHAIN_LEN-1:0] rx_next;

    always_ff @(posedge CK or posedge G_RESET) begin
        if (G_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counter restarts at every state change and saturates at the last shift index.
    always_ff @(posedge CK or posedge G_RESET) begin
        if (G_RESET) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (cnt != SHIFT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        shift_tx = 1'b0;
        shift_rx = 1'b0;
        res_upd  = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load    = 1'b1;
                    state_n = SHIFT_IN;
                end
            end
            SHIFT_IN: begin
                shift_tx = 1'b1;
                if (cnt == SHIFT_LAST) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cnt == CAP_LAST) begin
                    state_n = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                shift_rx = 1'b1;
                if (cnt == SHIFT_LAST) begin
                    res_upd = 1'b1;
                    state_n = FINISH;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Chain controls are registered from the next state so they line up with it.
    always_ff @(posedge CK or posedge G_RESET) begin
        if (G_RESET) begin
            SCAN_ENABLE <= 1'b0;
            SCAN_MODE   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RESULT_OUT  <= '0;
        end else begin
            SCAN_ENABLE <= (state_n == SHIFT_IN) || (state_n == SHIFT_OUT);
            SCAN_MODE   <= (state_n == SHIFT_IN) || (state_n == CAPTURE) ||
                           (state_n == SHIFT_OUT);
            BUSY        <= (state_n != IDLE);
            DONE        <= done_n;
            if (res_upd) begin
                RESULT_OUT <= rx_next;
            end
        end
    end

    rs_scan_shreg #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_shreg (
        .clk     (CK),
        .rst     (G_RESET),
        .load    (load),
        .shift_tx(shift_tx),
        .shift_rx(shift_rx),
        .par_in  (PATTERN_IN),
        .ser_in  (SO),
        .ser_out (SI),
        .rx_next (rx_next)
    );

`ifdef RS_SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;

    always_ff @(posedge CK) begin
        if (load) begin
            exp_q  <= EXPECT_IN;
            mask_q <= MASK_IN;
        end
    end

    // Evaluated on the FINISH edge so it becomes valid together with DONE.
    always_ff @(posedge CK or posedge G_RESET) begin
        if (G_RESET) begin
            MISMATCH <= 1'b0;
        end else if (done_n) begin
            MISMATCH <= |((RESULT_OUT ^ exp_q) & mask_q);
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = ^{EXPECT_IN, MASK_IN};
    assign MISMATCH   = 1'b0;
`endif

endmodule

// File: doc/rs_scan_ctrl.md
Name: rs_scan_ctrl

Overview:
- Scan-chain initiator for a chain of I/O scan flops; drives each flop's SI, SCAN_ENABLE and SCAN_MODE inputs and observes the chain's serial output.
- One operation: load a parallel pattern serially, pulse one functional capture cycle, unload the captured chain contents into a parallel result.
- Sits between the test/config controller and the IO ring scan chain.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (legal range ≥2).
- CNT_W, $clog2(CHAIN_LEN+1), width of the shift counter (derived; do not override).

Ports:
- CK  input  1  clock; the chain is clocked by the same CK while SCAN_MODE=1.
- G_RESET  input  1  asynchronous reset, active-high.
- START  input  1  request a load/capture/unload operation; sampled only in IDLE.
- PATTERN_IN  input  CHAIN_LEN  pattern to load; bit k lands in chain element k.
- EXPECT_IN  input  CHAIN_LEN  expected capture values; used only with the optional feature.
- MASK_IN  input  CHAIN_LEN  1 = compare bit k; used only with the optional feature.
- SO  input  1  serial output of the last chain element (element CHAIN_LEN-1).
- SI  output  1  serial data into chain element 0.
- SCAN_ENABLE  output  1  1 = chain shifts; 0 = chain captures D.
- SCAN_MODE  output  1  1 = chain clock bypasses the mode-select inversion.
- BUSY  output  1  high in every state other than IDLE.
- DONE  output  1  one-cycle pulse: RESULT_OUT valid.
- RESULT_OUT  output  CHAIN_LEN  unloaded chain contents; bit k = element k.
- MISMATCH  output  1  compare result; valid while DONE=1 and held until the next START.

Behaviour:
- All outputs are registered.
- Reset (async, immediate) values: state IDLE, SI=0, SCAN_ENABLE=0, SCAN_MODE=0, BUSY=0, DONE=0, RESULT_OUT=0, MISMATCH=0, counter=0.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH.
- IDLE:
  - START=1 latches PATTERN_IN into the TX shift register (and EXPECT_IN/MASK_IN when the feature is compiled in), then goes to SHIFT_IN.
  - At that edge: SI=PATTERN_IN[CHAIN_LEN-1], SCAN_ENABLE=1, SCAN_MODE=1, BUSY=1.
- SHIFT_IN:
  - Lasts exactly CHAIN_LEN cycles.
  - SI presents pattern bits MSB first, one bit per cycle.
  - After CHAIN_LEN shifting edges, element k holds PATTERN_IN[k].
  - Exits to CAPTURE with SCAN_ENABLE=0 and SI=0.
- CAPTURE:
  - Exactly 1 cycle with SCAN_ENABLE=0; the chain loads its functional D inputs on that edge.
  - Then goes to SHIFT_OUT with SCAN_ENABLE=1.
- SHIFT_OUT:
  - Lasts CHAIN_LEN cycles, SI=0.
  - On shifting edge j (j=0..CHAIN_LEN-1), SO is sampled into RESULT_OUT[CHAIN_LEN-1-j], so RESULT_OUT[k] = captured element k.
  - RESULT_OUT updates only on the final edge, from an internal RX register.
  - On exit to FINISH: SCAN_ENABLE=0, SCAN_MODE=0.
- FINISH:
  - DONE=1 for one cycle, BUSY=0 on the following edge, return to IDLE.
  - START seen in FINISH is ignored.
- Latency: START sampling edge to DONE high = 2*CHAIN_LEN+2 cycles.
- START while BUSY is ignored; no queuing.
- Counter: counts 0..CHAIN_LEN-1 and clears on every state change; no wrap beyond CHAIN_LEN-1.
- Reset mid-operation: the chain is left partially shifted. The controller makes no recovery attempt; the next START performs a full load.
- RESULT_OUT and MISMATCH hold their last values until the next operation completes.

Optional Feature:
- Macro: RS_SCAN_CTRL_COMPARE_EN.
- Defined:
  - MISMATCH = |((RESULT ^ EXPECT) & MASK), computed on the latched EXPECT/MASK.
  - MISMATCH is registered together with DONE.
- Undefined:
  - MISMATCH is tied to 0.
  - EXPECT_IN and MASK_IN are unused, and no latch registers are built for them.

Decomposition:
- Package rs_scan_pkg: state enum (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH) and the CAPTURE_CYCLES=1 constant.
- One sub-module, rs_scan_shreg: parameterised CHAIN_LEN piso/sipo pair with load/shift enables, holding the TX and RX registers.
- The FSM and counter live in rs_scan_ctrl.

Test Plan:
- Bench uses CHAIN_LEN=4 with a 4-flop behavioural chain model (SE mux + async-clear DFF).
- Load/unload loopback: chain D tied to its own Q, START with PATTERN_IN=4'b1011 → DONE at cycle 10, RESULT_OUT=4'b1011.
- Capture path: chain D=4'b0110, PATTERN_IN=4'b1001 → RESULT_OUT=4'b0110; SCAN_ENABLE low for exactly 1 cycle.
- Busy rejection: START pulsed at cycles 3 and 9 → exactly one DONE; BUSY high cycles 1–9.
- Reset mid-SHIFT_OUT: assert G_RESET at cycle 7 → all outputs 0 immediately; new START then yields correct RESULT_OUT=D.
- Compare (RS_SCAN_CTRL_COMPARE_EN): D=4'b0110, EXPECT_IN=4'b0111, MASK_IN=4'b1110 → MISMATCH=0; MASK_IN=4'b0001 → MISMATCH=1.
- Back-to-back: START held high continuously → operations complete every 11 cycles with a 1-cycle IDLE gap.
